// File: rtl/handshake_fifo.sv
// Byte buffer between two dav_/rfd handshake endpoints: the input side consumes,
// the output side produces, and up to DEPTH bytes are held in between.
module handshake_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int ADDR  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dav_in_,
  output logic             rfd_in,
  output logic [WIDTH-1:0] data_out,
  output logic             dav_out_,
  input  logic             rfd_out,
  output logic [ADDR:0]    count
);

  localparam logic [ADDR:0] FULL_COUNT = (ADDR+1)'(DEPTH);

  typedef enum logic {IN_WAIT, IN_ACK} in_state_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_SETUP, OUT_PRES, OUT_DONE} out_state_t;

  in_state_t        in_state_reg, in_state_next;
  out_state_t       out_state_reg, out_state_next;
  logic [1:0]       sync_in;
  logic [1:0]       sync_out;
  logic             dav_s_;
  logic             rfd_s;
  logic [ADDR-1:0]  wr_ptr_reg;
  logic [ADDR-1:0]  rd_ptr_reg;
  logic [ADDR:0]    count_reg;
  logic [WIDTH-1:0] data_out_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             not_full;
  logic             wr_en;
  logic             load_en;
  logic             pop_en;

  // Both handshake inputs idle high, so the chains preset to 1 on reset.
  assign sync_in = {rfd_out, dav_in_};
  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic [1:0] chain_reg;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) chain_reg <= 2'b11;
      else       chain_reg <= {chain_reg[0], sync_in[gi]};
    end
    assign sync_out[gi] = chain_reg[1];
  end
  assign dav_s_ = sync_out[0];
  assign rfd_s  = sync_out[1];

  assign not_full = (count_reg != FULL_COUNT);

  // Input FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) in_state_reg <= IN_WAIT;
    else       in_state_reg <= in_state_next;
  end

  always_comb begin
    in_state_next = in_state_reg;
    case (in_state_reg)
      IN_WAIT: if (!dav_s_ && not_full) in_state_next = IN_ACK;
      IN_ACK:  if (dav_s_)              in_state_next = IN_WAIT;
      default:                          in_state_next = IN_WAIT;
    endcase
  end

  always_comb begin
    rfd_in = (in_state_reg == IN_WAIT);
    wr_en  = (in_state_reg == IN_WAIT) && !dav_s_ && not_full;
  end

  // Output FSM; SETUP gives data_out a full clock before dav_out_ falls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) out_state_reg <= OUT_IDLE;
    else       out_state_reg <= out_state_next;
  end

  always_comb begin
    out_state_next = out_state_reg;
    case (out_state_reg)
      OUT_IDLE:  if (count_reg != '0 && rfd_s) out_state_next = OUT_SETUP;
      OUT_SETUP:                               out_state_next = OUT_PRES;
      OUT_PRES:  if (!rfd_s)                   out_state_next = OUT_DONE;
      OUT_DONE:  if (rfd_s)                    out_state_next = OUT_IDLE;
      default:                                 out_state_next = OUT_IDLE;
    endcase
  end

  always_comb begin
    dav_out_ = (out_state_reg != OUT_PRES);
    load_en  = (out_state_reg == OUT_IDLE) && (count_reg != '0) && rfd_s;
    pop_en   = (out_state_reg == OUT_PRES) && !rfd_s;
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_reg] <= data_in;
  end

  // Pointers wrap naturally; count alone tells full from empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      data_out_reg <= '0;
    end else begin
      if (wr_en)   wr_ptr_reg   <= wr_ptr_reg + ADDR'(1);
      if (pop_en)  rd_ptr_reg   <= rd_ptr_reg + ADDR'(1);
      if (load_en) data_out_reg <= mem[rd_ptr_reg];
      case ({wr_en, pop_en})
        2'b10:   count_reg <= count_reg + (ADDR+1)'(1);
        2'b01:   count_reg <= count_reg - (ADDR+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign data_out = data_out_reg;
  assign count    = count_reg;

endmodule

// File: tb/tb_handshake_fifo.sv
// Directed bench for handshake_fifo: a vector table for single-byte transfers
// plus hand-written fill, wrap, simultaneous, hold and reset sequences.
module tb_handshake_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int ADDR  = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] data_in = '0;
  logic             dav_in_ = 1'b1;
  logic             rfd_in;
  logic [WIDTH-1:0] data_out;
  logic             dav_out_;
  logic             rfd_out = 1'b1;
  logic [ADDR:0]    count;

  handshake_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
    .clock    (clock),
    .reset    (reset),
    .data_in  (data_in),
    .dav_in_  (dav_in_),
    .rfd_in   (rfd_in),
    .data_out (data_out),
    .dav_out_ (dav_out_),
    .rfd_out  (rfd_out),
    .count    (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t single_tab[4];
  vec_t fill_tab[5];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_rfd_in(input logic val, input int budget, input string name);
    int i = 0;
    while (rfd_in !== val && i < budget) begin
      tick(1);
      i++;
    end
    total++;
    if (rfd_in === val) passed++;
    else $display("FAIL %s: rfd_in is %b, expected %b within %0d cycles", name, rfd_in, val, budget);
  endtask

  task automatic wait_dav_out(input logic val, input int budget, input string name);
    int i = 0;
    while (dav_out_ !== val && i < budget) begin
      tick(1);
      i++;
    end
    total++;
    if (dav_out_ === val) passed++;
    else $display("FAIL %s: dav_out_ is %b, expected %b within %0d cycles", name, dav_out_, val, budget);
  endtask

  task automatic write_byte(input logic [7:0] din, input int budget, input string name);
    data_in = din;
    dav_in_ = 1'b0;
    wait_rfd_in(1'b0, budget, {name, "_ack"});
    dav_in_ = 1'b1;
    wait_rfd_in(1'b1, budget, {name, "_rel"});
  endtask

  task automatic read_byte(output logic [7:0] got, input int budget, input string name);
    rfd_out = 1'b1;
    wait_dav_out(1'b0, budget, {name, "_dav"});
    got = data_out;
    rfd_out = 1'b0;
    wait_dav_out(1'b1, budget, {name, "_pop"});
    rfd_out = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

  initial begin
    logic [7:0] got;

    single_tab[0] = '{8'hA5, 8'hA5, 3'd1};
    single_tab[1] = '{8'h00, 8'h00, 3'd1};
    single_tab[2] = '{8'hFF, 8'hFF, 3'd1};
    single_tab[3] = '{8'h3C, 8'h3C, 3'd1};
    fill_tab[0]   = '{8'h11, 8'h11, 3'd1};
    fill_tab[1]   = '{8'h22, 8'h22, 3'd2};
    fill_tab[2]   = '{8'h33, 8'h33, 3'd3};
    fill_tab[3]   = '{8'h44, 8'h44, 3'd4};
    fill_tab[4]   = '{8'h55, 8'h55, 3'd4};

    // Reset held, then released and idle
    tick(2);
    check("rst_rfd_in", rfd_in, 1);
    check("rst_dav_out", dav_out_, 1);
    check("rst_data_out", data_out, 0);
    check("rst_count", count, 0);
    reset = 1'b0;
    tick(3);
    check("idle_rfd_in", rfd_in, 1);
    check("idle_dav_out", dav_out_, 1);
    check("idle_count", count, 0);

    // Single-byte transfers with exact cycle timing
    for (int v = 0; v < 4; v++) begin
      data_in = single_tab[v].din;
      dav_in_ = 1'b0;
      tick(2);
      check($sformatf("v%0d_rfd_in_early", v), rfd_in, 1);
      tick(1);
      check($sformatf("v%0d_rfd_in_fall", v), rfd_in, 0);
      check($sformatf("v%0d_count_wr", v), count, single_tab[v].exp_cnt);
      dav_in_ = 1'b1;
      tick(1);
      check($sformatf("v%0d_data_out", v), data_out, single_tab[v].exp_dout);
      check($sformatf("v%0d_dav_out_setup", v), dav_out_, 1);
      tick(1);
      check($sformatf("v%0d_dav_out_fall", v), dav_out_, 0);
      rfd_out = 1'b0;
      tick(2);
      check($sformatf("v%0d_dav_out_hold", v), dav_out_, 0);
      check($sformatf("v%0d_count_hold", v), count, single_tab[v].exp_cnt);
      tick(1);
      check($sformatf("v%0d_dav_out_rise", v), dav_out_, 1);
      check($sformatf("v%0d_count_pop", v), count, 0);
      rfd_out = 1'b1;
      tick(4);
      check($sformatf("v%0d_rfd_in_back", v), rfd_in, 1);
    end

    // Reset asserted while a byte is presented
    data_in = 8'h5A;
    dav_in_ = 1'b0;
    wait_rfd_in(1'b0, 10, "midrst_ack");
    dav_in_ = 1'b1;
    wait_dav_out(1'b0, 10, "midrst_pres");
    #2 reset = 1'b1;
    #1;
    check("midrst_dav_out", dav_out_, 1);
    check("midrst_count", count, 0);
    check("midrst_rfd_in", rfd_in, 1);
    check("midrst_data_out", data_out, 0);
    @(negedge clock);
    reset = 1'b0;
    tick(8);
    check("postrst_dav_out", dav_out_, 1);
    check("postrst_count", count, 0);

    // Fill while the consumer is busy, then block a fifth byte
    rfd_out = 1'b0;
    tick(3);
    for (int v = 0; v < 4; v++) begin
      write_byte(fill_tab[v].din, 20, $sformatf("fill%0d", v));
      check($sformatf("fill%0d_count", v), count, fill_tab[v].exp_cnt);
    end
    data_in = fill_tab[4].din;
    dav_in_ = 1'b0;
    tick(12);
    check("full_rfd_in", rfd_in, 1);
    check("full_count", count, 4);
    read_byte(got, 20, "full_rd0");
    check("full_rd0_data", got, fill_tab[0].exp_dout);
    wait_rfd_in(1'b0, 10, "full_late_ack");
    check("full_late_count", count, fill_tab[4].exp_cnt);
    dav_in_ = 1'b1;
    wait_rfd_in(1'b1, 10, "full_late_rel");
    for (int v = 1; v < 5; v++) begin
      read_byte(got, 20, $sformatf("full_rd%0d", v));
      check($sformatf("full_rd%0d_data", v), got, fill_tab[v].exp_dout);
    end
    check("full_drained", count, 0);

    // Write and pop land on the same edge at count=2
    rfd_out = 1'b0;
    tick(3);
    write_byte(8'hA1, 20, "sim_w0");
    write_byte(8'hA2, 20, "sim_w1");
    rfd_out = 1'b1;
    wait_dav_out(1'b0, 20, "sim_pres");
    check("sim_data_a1", data_out, 8'hA1);
    data_in = 8'hA3;
    dav_in_ = 1'b0;
    rfd_out = 1'b0;
    tick(2);
    check("sim_count_before", count, 2);
    check("sim_rfd_in_before", rfd_in, 1);
    tick(1);
    check("sim_count_after", count, 2);
    check("sim_dav_out_after", dav_out_, 1);
    check("sim_rfd_in_after", rfd_in, 0);
    dav_in_ = 1'b1;
    wait_rfd_in(1'b1, 10, "sim_rel");
    read_byte(got, 20, "sim_rd1");
    check("sim_data_a2", got, 8'hA2);
    read_byte(got, 20, "sim_rd2");
    check("sim_data_a3", got, 8'hA3);
    check("sim_drained", count, 0);

    // Producer keeps dav_in_ low long after the acknowledge
    rfd_out = 1'b0;
    tick(3);
    data_in = 8'h77;
    dav_in_ = 1'b0;
    tick(3);
    check("hold_rfd_in_fall", rfd_in, 0);
    check("hold_count_1", count, 1);
    tick(10);
    check("hold_rfd_in_low", rfd_in, 0);
    check("hold_count_still", count, 1);
    dav_in_ = 1'b1;
    tick(2);
    check("hold_rfd_in_early", rfd_in, 0);
    tick(1);
    check("hold_rfd_in_rise", rfd_in, 1);
    check("hold_count_final", count, 1);
    read_byte(got, 20, "hold_rd");
    check("hold_data", got, 8'h77);
    check("hold_drained", count, 0);

    // Ten bytes through a slow consumer: pointers wrap twice
    fork
      begin
        for (int i = 0; i < 10; i++) write_byte(8'(i), 200, $sformatf("order_wr%0d", i));
      end
      begin
        logic [7:0] got_o;
        for (int j = 0; j < 10; j++) begin
          read_byte(got_o, 200, $sformatf("order_rd%0d", j));
          check($sformatf("order_data%0d", j), got_o, 8'(j));
          tick(8);
        end
      end
    join
    check("order_drained", count, 0);
    check("order_rfd_in", rfd_in, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/handshake_fifo.md
Name: handshake_fifo

Overview:
- Byte buffer between two dav_/rfd handshake endpoints, e.g. a serial receiver's parallel output and a serial transmitter's parallel input.
- The input side acts as consumer and the output side acts as producer.
- It decouples a bursty producer from a slow serialising consumer by holding up to DEPTH bytes.
- Handshake inputs are synchronised internally, so the producer and consumer may run on unrelated clocks.

Parameters:
WIDTH, 8, data bus width in bits
DEPTH, 4, number of storage slots; must be a power of 2
ADDR, 2, log2(DEPTH); pointer width

Ports:
clock  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
data_in  input  WIDTH  byte from upstream producer; stable while dav_in_=0
dav_in_  input  1  upstream data valid, active-low
rfd_in  output  1  ready-for-data to upstream; 1=ready, falls to acknowledge a captured byte
data_out  output  WIDTH  byte offered downstream
dav_out_  output  1  downstream data valid, active-low
rfd_out  input  1  downstream ready-for-data; falls to acknowledge
count  output  ADDR+1  number of bytes currently stored, 0..DEPTH

Behaviour:
Interface:
- One clock; reset is asynchronous and active-high.
- Ports are named clock and reset.

Reset (async, immediate):
- rfd_in=1, dav_out_=1, data_out=0, count=0.
- Both pointers=0; both FSMs in their idle states.
- Both synchroniser chains preset to 1 (inactive).
- Reset mid-handshake aborts the transfer and discards stored bytes. The upstream producer then sees rfd_in=1.

Synchronisers:
- dav_in_ and rfd_out each pass through a 2-flop chain; the FSMs use only the synchronised copies (dav_s_, rfd_s).
- data_in is sampled directly. The protocol guarantees it is stable from dav_in_ fall until rfd_in falls.

Input FSM:
- IN_WAIT: rfd_in=1.
  - If dav_s_==0 and count<DEPTH: mem[wr]<=data_in, wr<=wr+1 mod DEPTH, rfd_in<=0, go IN_ACK.
  - If full: stay, rfd_in stays 1, and the producer waits.
- IN_ACK: hold rfd_in=0. When dav_s_==1: rfd_in<=1, go IN_WAIT.
- Latency: rfd_in falls on the 3rd posedge after dav_in_ falls (2 sync + 1).

Output FSM:
- OUT_IDLE: dav_out_=1. If count>0 and rfd_s==1: data_out<=mem[rd], go OUT_SETUP.
- OUT_SETUP: dav_out_<=0, go OUT_PRES. This gives one full clock of data setup before dav_out_ falls.
- OUT_PRES: hold. When rfd_s==0: dav_out_<=1, rd<=rd+1 mod DEPTH, go OUT_DONE. This is the pop.
- OUT_DONE: when rfd_s==1, go OUT_IDLE.
- data_out holds its last value outside OUT_SETUP loads.

Count and timing:
- count: +1 on write, -1 on pop; unchanged when both happen in the same cycle.
- A write into an empty FIFO is seen by OUT_IDLE at the next edge: data_out loads at the 1st edge after the write edge, and dav_out_ falls at the 2nd.
- Full (count==DEPTH) blocks writes only; empty (count==0) blocks presentation only. Neither is an error.
- Pointers wrap silently; count alone distinguishes full from empty.

Test Plan:
- Reset then idle → rfd_in=1, dav_out_=1, data_out=0, count=0; asserting reset mid-OUT_PRES returns dav_out_=1 immediately and count=0.
- Single byte: data_in=0xA5, dav_in_ low, rfd_out held 1 → rfd_in low 3 clocks later; count=1; data_out=0xA5 then dav_out_ low 1 clock after; rfd_out pulsed low → dav_out_ high, count=0.
- Fill: rfd_out held 0 (consumer busy), write 0x11,0x22,0x33,0x44 → count=4; 5th byte 0x55 with dav_in_ low → rfd_in stays 1 indefinitely; release consumer → 0x55 accepted after first pop.
- Order and wrap: stream 10 bytes 0x00..0x09 with consumer slower than producer → output sequence exactly 0x00..0x09; pointers wrap twice with no loss or duplication.
- Simultaneous: a write and a pop on the same edge at count=2 → count stays 2 and the data order is preserved.
- Protocol hold: dav_in_ kept low after rfd_in falls → rfd_in stays 0 and no second write occurs; dav_in_ rises → rfd_in returns to 1 three clocks later.
